// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : common
//  Description : Shared bus request/response types, access sizes and the
//                memory-port arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package common;

    // Access size encoding carried on the data bus request
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Arbiter states: idle, fetch port granted, memory-stage port granted
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage : common
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one downstream memory port between the fetch bus and
//                the memory-stage bus. Data bus has priority, bounded by a
//                starvation counter that forces an ibus grant after
//                STARVE_LIMIT consecutive dbus grants while ibus waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import common::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp,
    output logic       busy
);

    localparam int          C_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    arb_state_t         state_q, state_d;
    logic [C_CNT_W-1:0] starve_q, starve_d;
    dbus_req_t          req_q, req_d;

    // State, starvation counter and latched request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            req_q    <= req_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until data_ok
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        req_d    = req_q;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid && ((starve_q < C_LIMIT) || !ireq.valid)) begin
                    state_d = GRANT_D;
                    req_d   = dreq;
                    // Only count dbus wins that actually made ibus wait
                    if (ireq.valid && (starve_q != C_LIMIT)) begin
                        starve_d = starve_q + C_CNT_W'(1);
                    end
                end else if (ireq.valid) begin
                    state_d  = GRANT_I;
                    starve_d = '0;
                    req_d    = '{valid: 1'b1, addr: ireq.addr, size: MSIZE4,
                                 strobe: 8'h00, data: 64'h0};
                end
            end
            GRANT_I, GRANT_D: begin
                if (oresp.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output steering: downstream request and responses follow the grant
    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        busy  = (state_q != IDLE);
        if (state_q != IDLE) begin
            oreq = req_q;
        end
        if (state_q == GRANT_I) begin
            iresp.addr_ok = oresp.addr_ok;
            iresp.data_ok = oresp.data_ok;
            // Fetch is 32 bits wide; pick the word within the 64-bit beat
            iresp.data    = req_q.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
        end
        if (state_q == GRANT_D) begin
            dresp.addr_ok = oresp.addr_ok;
            dresp.data_ok = oresp.data_ok;
            dresp.data    = oresp.data;
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import common::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  oreq;
    dbus_resp_t oresp;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    dbus_req_t exp_req;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive data_ok for the current grant and step back into IDLE
    task automatic complete(input logic [63:0] data);
        oresp.data_ok = 1'b1;
        oresp.data    = data;
        cyc();
        oresp = '0;
        #1;
        chk("idle_after_done_busy", 128'(busy), 128'(1'b0));
        chk("idle_after_done_oreq", 128'(oreq), 128'(0));
    endtask

    initial begin
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        cyc();
        cyc();
        // Reset state
        chk("rst_oreq",  128'(oreq),  128'(0));
        chk("rst_busy",  128'(busy),  128'(1'b0));
        chk("rst_iresp", 128'(iresp), 128'(0));
        chk("rst_dresp", 128'(dresp), 128'(0));
        #2 reset = 1'b0;
        cyc();
        chk("post_rst_busy", 128'(busy), 128'(1'b0));

        // Lone fetch, upper word selected by addr[2]
        ireq = '{valid: 1'b1, addr: 32'h8000_0004};
        cyc();
        exp_req = '{valid: 1'b1, addr: 32'h8000_0004, size: MSIZE4, strobe: 8'h00, data: 64'h0};
        chk("fetch_oreq", 128'(oreq), 128'(exp_req));
        chk("fetch_busy", 128'(busy), 128'(1'b1));
        ireq.valid = 1'b0;       // dropping valid must not abort the grant
        oresp.data = 64'h1122_3344_5566_7788;
        cyc();
        cyc();
        chk("fetch_hold_oreq", 128'(oreq), 128'(exp_req));
        oresp.data_ok = 1'b1;
        #1;
        chk("fetch_iresp_ok",   128'(iresp.data_ok), 128'(1'b1));
        chk("fetch_iresp_data", 128'(iresp.data),    128'(32'h1122_3344));
        chk("fetch_dresp_zero", 128'(dresp),         128'(0));
        complete(64'h1122_3344_5566_7788);

        // Simultaneous requests: dbus first, then ibus after one idle cycle
        ireq = '{valid: 1'b1, addr: 32'h8000_0000};
        dreq = '{valid: 1'b1, addr: 32'h10, size: MSIZE8, strobe: 8'hFF, data: 64'hAABB_CCDD_0011_2233};
        cyc();
        chk("sim_d_addr",   128'(oreq.addr), 128'(32'h10));
        chk("sim_d_strobe", 128'(oreq.strobe), 128'(8'hFF));
        chk("sim_starve1",  128'(dut.starve_q), 128'(1));
        dreq.addr = 32'h20;
        oresp.addr_ok = 1'b1;
        #1;
        chk("stable_addr",    128'(oreq.addr),     128'(32'h10));
        chk("d_addr_ok",      128'(dresp.addr_ok), 128'(1'b1));
        chk("i_addr_ok_zero", 128'(iresp),         128'(0));
        cyc();
        chk("stable_addr2", 128'(oreq.addr), 128'(32'h10));
        oresp.data_ok = 1'b1;
        oresp.data    = 64'hDEAD_BEEF_CAFE_F00D;
        dreq.valid    = 1'b0;
        #1;
        chk("d_data",    128'(dresp.data),    128'(64'hDEAD_BEEF_CAFE_F00D));
        chk("d_data_ok", 128'(dresp.data_ok), 128'(1'b1));
        chk("d_i_zero",  128'(iresp),         128'(0));
        complete(64'hDEAD_BEEF_CAFE_F00D);
        cyc();
        exp_req = '{valid: 1'b1, addr: 32'h8000_0000, size: MSIZE4, strobe: 8'h00, data: 64'h0};
        chk("sim_i_oreq",   128'(oreq), 128'(exp_req));
        chk("sim_starve0",  128'(dut.starve_q), 128'(0));
        oresp.data_ok = 1'b1;
        oresp.data    = 64'h1122_3344_5566_7788;
        #1;
        chk("i_low_word", 128'(iresp.data), 128'(32'h5566_7788));
        chk("i_d_zero",   128'(dresp),      128'(0));
        complete(64'h1122_3344_5566_7788);

        // Starvation: four dbus wins, then ibus forced through
        ireq = '{valid: 1'b1, addr: 32'h8000_0100};
        dreq = '{valid: 1'b1, addr: 32'h40, size: MSIZE4, strobe: 8'h0F, data: 64'h5};
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("starve_d_addr", 128'(oreq.addr), 128'(32'h40));
            chk("starve_cnt",    128'(dut.starve_q), 128'(k));
            complete(64'h0);
        end
        cyc();
        chk("starve_i_addr", 128'(oreq.addr), 128'(32'h8000_0100));
        chk("starve_i_size", 128'(oreq.size), 128'(MSIZE4));
        chk("starve_clear",  128'(dut.starve_q), 128'(0));
        ireq.valid = 1'b0;
        complete(64'h0);

        // dbus entry with ibus idle leaves the counter alone
        ireq.valid = 1'b1;
        cyc();
        chk("cnt_one", 128'(dut.starve_q), 128'(1));
        ireq.valid = 1'b0;
        complete(64'h0);
        cyc();
        chk("no_ireq_d_grant", 128'(oreq.addr), 128'(32'h40));
        chk("cnt_unchanged",   128'(dut.starve_q), 128'(1));
        dreq.valid = 1'b0;
        complete(64'h0);

        // Reset in the middle of a fetch grant
        ireq = '{valid: 1'b1, addr: 32'h8000_0200};
        cyc();
        chk("pre_rst_busy", 128'(busy), 128'(1'b1));
        #2 reset = 1'b1;
        oresp.data_ok = 1'b1;
        #1;
        chk("midrst_oreq_valid", 128'(oreq.valid), 128'(1'b0));
        chk("midrst_busy",       128'(busy),       128'(1'b0));
        chk("midrst_iresp",      128'(iresp),      128'(0));
        chk("midrst_starve",     128'(dut.starve_q), 128'(0));
        cyc();
        #2 reset = 1'b0;
        oresp = '0;
        #1;
        chk("rel_idle", 128'(busy), 128'(1'b0));
        cyc();
        chk("rel_grant_i", 128'(oreq.addr), 128'(32'h8000_0200));
        ireq.valid = 1'b0;
        complete(64'h0);

        // Spurious data_ok in IDLE is ignored
        oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hFFFF_FFFF_FFFF_FFFF};
        #1;
        chk("spur_iresp", 128'(iresp), 128'(0));
        chk("spur_dresp", 128'(dresp), 128'(0));
        cyc();
        chk("spur_busy", 128'(busy), 128'(1'b0));
        chk("spur_oreq", 128'(oreq), 128'(0));
        oresp = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
